// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode constants used by fetch and decode, plus the
// fetch FSM state type.
package cpu_pkg;

  localparam logic [15:0] NOP_INSTR = 16'h0000;

  localparam logic [4:0] OPC_LDM = 5'b10100;
  localparam logic [4:0] OPC_LDD = 5'b10101;
  localparam logic [4:0] OPC_STD = 5'b10110;

  typedef enum logic {
    S_FETCH,
    S_IMM
  } fetch_state_t;

  // These opcodes carry a 16-bit immediate in the word that follows them
  function automatic logic is_two_word(input logic [4:0] opcode);
    return (opcode == OPC_LDM) || (opcode == OPC_LDD) || (opcode == OPC_STD);
  endfunction

endpackage

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, reads the async instruction memory and fills
// the IF/ID register, merging opcode + immediate words into one entry.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int unsigned          IMEM_AW  = 16,
  parameter logic [IMEM_AW-1:0]   RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               jump_occured,
  input  logic [IMEM_AW-1:0] jump_target,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [15:0]        imem_data,
  output logic [15:0]        instruction,
  output logic [15:0]        immediate,
  output logic [IMEM_AW-1:0] pc_plus1_buf,
  output logic               valid_buf
);

  logic [IMEM_AW-1:0] pc;
  logic [IMEM_AW-1:0] pc_next_seq;
  logic [15:0]        hold_word;
  fetch_state_t       state;

  assign imem_addr   = pc;
  assign pc_next_seq = pc + 1'b1;

  // A jump discards any half-assembled two-word instruction and wins over stall
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc           <= RESET_PC;
      state        <= S_FETCH;
      hold_word    <= 16'h0000;
      instruction  <= NOP_INSTR;
      immediate    <= 16'h0000;
      pc_plus1_buf <= '0;
      valid_buf    <= 1'b0;
    end else if (jump_occured) begin
      pc          <= jump_target;
      state       <= S_FETCH;
      instruction <= NOP_INSTR;
      immediate   <= 16'h0000;
      valid_buf   <= 1'b0;
    end else if (!stall) begin
      pc <= pc_next_seq;
      case (state)
        S_FETCH: begin
          if (is_two_word(imem_data[15:11])) begin
            hold_word   <= imem_data;
            instruction <= NOP_INSTR;
            immediate   <= 16'h0000;
            valid_buf   <= 1'b0;
            state       <= S_IMM;
          end else begin
            instruction  <= imem_data;
            immediate    <= 16'h0000;
            pc_plus1_buf <= pc_next_seq;
            valid_buf    <= 1'b1;
          end
        end
        S_IMM: begin
          instruction  <= hold_word;
          immediate    <= imem_data;
          pc_plus1_buf <= pc_next_seq;
          valid_buf    <= 1'b1;
          state        <= S_FETCH;
        end
        default: state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed programs push expected IF/ID
// entries, a monitor pops them whenever a fresh valid entry appears.
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        jump_occured;
  logic [15:0] jump_target;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic [15:0] instruction;
  logic [15:0] immediate;
  logic [15:0] pc_plus1_buf;
  logic        valid_buf;

  logic [15:0] imem [0:65535];

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] imm;
    logic [15:0] pc1;
  } exp_t;

  exp_t sb[$];
  int   compared;
  int   mismatched;

  fetch_stage #(.IMEM_AW(16), .RESET_PC(16'h0000)) dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .jump_occured (jump_occured),
    .jump_target  (jump_target),
    .imem_addr    (imem_addr),
    .imem_data    (imem_data),
    .instruction  (instruction),
    .immediate    (immediate),
    .pc_plus1_buf (pc_plus1_buf),
    .valid_buf    (valid_buf)
  );

  assign imem_data = imem[imem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Only edges taken out of reset with no stall or jump can load a new entry
  initial begin : monitor
    logic adv;
    exp_t e;
    forever begin
      @(posedge clk);
      adv = reset && !stall && !jump_occured;
      @(negedge clk);
      if (valid_buf) begin
        if (adv) begin
          if (sb.size() == 0) begin
            check("unexpected_entry", {16'h0, instruction}, 32'hFFFF_FFFF);
          end else begin
            e = sb.pop_front();
            check("sb_instruction", {16'h0, instruction}, {16'h0, e.instr});
            check("sb_immediate", {16'h0, immediate}, {16'h0, e.imm});
            check("sb_pc_plus1", {16'h0, pc_plus1_buf}, {16'h0, e.pc1});
          end
        end
      end else begin
        check("bubble_instruction", {16'h0, instruction}, 32'h0);
        check("bubble_immediate", {16'h0, immediate}, 32'h0);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: got timeout, required completion");
    $fatal(1, "[TB] simulation did not complete");
  end

  task automatic push(input logic [15:0] i, input logic [15:0] m, input logic [15:0] p);
    exp_t e;
    e.instr = i;
    e.imm   = m;
    e.pc1   = p;
    sb.push_back(e);
  endtask

  // Enters reset with stall raised and wipes program memory
  task automatic applyReset();
    @(negedge clk);
    #1;
    reset        = 1'b0;
    stall        = 1'b1;
    jump_occured = 1'b0;
    jump_target  = 16'h0;
    for (int i = 0; i < 65536; i++) imem[i] = 16'h0000;
  endtask

  task automatic releaseReset();
    @(negedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic runCycles(input int n);
    @(negedge clk);
    #1 stall = 1'b0;
    repeat (n) @(posedge clk);
    #1 stall = 1'b1;
  endtask

  task automatic applyJump(input logic [15:0] target);
    @(negedge clk);
    #1;
    jump_occured = 1'b1;
    jump_target  = target;
    @(posedge clk);
    #1 jump_occured = 1'b0;
  endtask

  task automatic settle();
    @(negedge clk);
    #2;
  endtask

  initial begin : stimulus
    compared     = 0;
    mismatched   = 0;
    reset        = 1'b0;
    stall        = 1'b1;
    jump_occured = 1'b0;
    jump_target  = 16'h0;

    // Reset values, then a single one-word instruction
    applyReset();
    imem[0] = 16'h0820;
    settle();
    check("rst_imem_addr", {16'h0, imem_addr}, 32'h0);
    check("rst_instruction", {16'h0, instruction}, 32'h0);
    check("rst_valid", {31'h0, valid_buf}, 32'h0);
    check("rst_pc_plus1", {16'h0, pc_plus1_buf}, 32'h0);
    push(16'h0820, 16'h0000, 16'h0001);
    releaseReset();
    runCycles(1);
    settle();
    check("t1_instruction", {16'h0, instruction}, 32'h0820);
    check("t1_pc_plus1", {16'h0, pc_plus1_buf}, 32'h1);
    check("t1_valid", {31'h0, valid_buf}, 32'h1);

    // LDM assembly over two edges
    applyReset();
    imem[0] = 16'hA100;
    imem[1] = 16'h1234;
    push(16'hA100, 16'h1234, 16'h0002);
    releaseReset();
    runCycles(1);
    settle();
    check("t2_bubble_valid", {31'h0, valid_buf}, 32'h0);
    check("t2_addr_edge1", {16'h0, imem_addr}, 32'h1);
    runCycles(1);
    settle();
    check("t2_addr_edge2", {16'h0, imem_addr}, 32'h2);

    // Stall for three cycles at pc=5
    applyReset();
    for (int i = 0; i < 7; i++) imem[i] = 16'h0801 + 16'(i);
    for (int i = 0; i < 5; i++) push(16'h0801 + 16'(i), 16'h0, 16'(i + 1));
    releaseReset();
    runCycles(5);
    for (int k = 0; k < 3; k++) begin
      settle();
      check("t3_stall_addr", {16'h0, imem_addr}, 32'h5);
      check("t3_stall_instr", {16'h0, instruction}, 32'h0805);
      check("t3_stall_pc1", {16'h0, pc_plus1_buf}, 32'h5);
    end
    push(16'h0806, 16'h0, 16'h0006);
    push(16'h0807, 16'h0, 16'h0007);
    runCycles(2);
    settle();
    check("t3_resume_addr", {16'h0, imem_addr}, 32'h7);

    // Jump during S_IMM with stall also high drops the held LDD word
    applyReset();
    imem[0]     = 16'hA900;
    imem[1]     = 16'h5555;
    imem[16'h40] = 16'h0840;
    releaseReset();
    runCycles(1);
    applyJump(16'h0040);
    settle();
    check("t4_addr", {16'h0, imem_addr}, 32'h40);
    check("t4_instruction", {16'h0, instruction}, 32'h0);
    check("t4_valid", {31'h0, valid_buf}, 32'h0);
    push(16'h0840, 16'h0, 16'h0041);
    runCycles(1);
    settle();
    check("t4_after_addr", {16'h0, imem_addr}, 32'h41);

    // Top-of-memory wrap, one-word
    applyReset();
    imem[16'hFFFF] = 16'h0811;
    releaseReset();
    applyJump(16'hFFFF);
    push(16'h0811, 16'h0, 16'h0000);
    runCycles(1);
    settle();
    check("t5_wrap_addr", {16'h0, imem_addr}, 32'h0);
    check("t5_wrap_pc1", {16'h0, pc_plus1_buf}, 32'h0);

    // Top-of-memory wrap, immediate comes from address 0
    applyReset();
    imem[16'hFFFF] = 16'hA1AB;
    imem[0]        = 16'hBEEF;
    releaseReset();
    applyJump(16'hFFFF);
    push(16'hA1AB, 16'hBEEF, 16'h0001);
    runCycles(2);
    settle();
    check("t5_ldm_wrap_addr", {16'h0, imem_addr}, 32'h1);

    // Mixed stream: STD, one-word ops and the opcode right after STD
    applyReset();
    imem[0] = 16'hB0AA;
    imem[1] = 16'h00C3;
    imem[2] = 16'h1802;
    imem[3] = 16'hB800;
    imem[4] = 16'h9F00;
    push(16'hB0AA, 16'h00C3, 16'h0002);
    push(16'h1802, 16'h0000, 16'h0003);
    push(16'hB800, 16'h0000, 16'h0004);
    push(16'h9F00, 16'h0000, 16'h0005);
    releaseReset();
    runCycles(5);
    settle();
    check("t7_addr", {16'h0, imem_addr}, 32'h5);

    // Asynchronous reset mid-cycle while in S_IMM
    applyReset();
    imem[0] = 16'hA100;
    imem[1] = 16'h1234;
    releaseReset();
    runCycles(1);
    settle();
    check("t6_pre_addr", {16'h0, imem_addr}, 32'h1);
    #1 reset = 1'b0;
    #1;
    check("t6_async_addr", {16'h0, imem_addr}, 32'h0);
    check("t6_async_valid", {31'h0, valid_buf}, 32'h0);
    check("t6_async_instr", {16'h0, instruction}, 32'h0);
    push(16'hA100, 16'h1234, 16'h0002);
    releaseReset();
    runCycles(2);
    settle();
    check("t6_restart_addr", {16'h0, imem_addr}, 32'h2);

    repeat (2) @(negedge clk);
    check("sb_drained", sb.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
